// File: rtl/cond_writeback_pkg.sv
// Shared encodings for the execute/writeback boundary: condition codes,
// NZCV bit positions and the ALU command set.
package cond_writeback_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_ORR = 4'd3,
    ALU_EOR = 4'd4,
    ALU_MOV = 4'd5,
    ALU_CMP = 4'd6,
    ALU_TST = 4'd7,
    ALU_ADC = 4'd8,
    ALU_SBC = 4'd9,
    ALU_LSL = 4'd10,
    ALU_LSR = 4'd11,
    ALU_ASR = 4'd12,
    ALU_MVN = 4'd13,
    ALU_BIC = 4'd14,
    ALU_NOP = 4'd15
  } alu_cmd_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  function automatic nzcv_t unpack_nzcv(input logic [3:0] f);
    nzcv_t r;
    r.n = f[FLAG_N];
    r.z = f[FLAG_Z];
    r.c = f[FLAG_C];
    r.v = f[FLAG_V];
    return r;
  endfunction

endpackage

// File: rtl/cond_writeback_if.sv
// Upstream ALU-result handshake plus downstream register-file writeback
// handshake, bundled so producer and consumer share one port.
interface cond_writeback_if #(
  parameter int DW = 32,
  parameter int RW = 4
) ();

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_cond;
  logic          in_set_flags;
  logic          in_reg_write;
  logic [RW-1:0] in_rd;
  logic [DW-1:0] in_result;
  logic [3:0]    in_flags;

  logic          wb_valid;
  logic          wb_ready;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  // Environment side: drives ALU results, consumes writebacks.
  modport master (
    output in_valid, in_cond, in_set_flags, in_reg_write, in_rd, in_result, in_flags,
    input  in_ready,
    input  wb_valid, wb_rd, wb_data,
    output wb_ready
  );

  // Block side.
  modport slave (
    input  in_valid, in_cond, in_set_flags, in_reg_write, in_rd, in_result, in_flags,
    output in_ready,
    output wb_valid, wb_rd, wb_data,
    input  wb_ready
  );

endinterface

// File: rtl/cond_writeback_cond_check.sv
// Purely combinational evaluation of a 4-bit condition field against NZCV.
module cond_check
  import cond_writeback_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  nzcv_t f;

  always_comb begin
    f    = unpack_nzcv(nzcv);
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = f.z;
      COND_NE: pass = !f.z;
      COND_CS: pass = f.c;
      COND_CC: pass = !f.c;
      COND_MI: pass = f.n;
      COND_PL: pass = !f.n;
      COND_VS: pass = f.v;
      COND_VC: pass = !f.v;
      COND_HI: pass = f.c && !f.z;
      COND_LS: pass = !f.c || f.z;
      COND_GE: pass = (f.n == f.v);
      COND_LT: pass = (f.n != f.v);
      COND_GT: pass = !f.z && (f.n == f.v);
      COND_LE: pass = f.z || (f.n != f.v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_writeback.sv
// Conditional-execution writeback stage: squashes condition-failed results,
// maintains NZCV and buffers register writes in a 2-entry FIFO.
module cond_writeback
  import cond_writeback_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  cond_writeback_if.slave bus,
  output logic [3:0]    flags_q,
  output logic [CW-1:0] exec_cnt,
  output logic [CW-1:0] squash_cnt
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [3:0]    flags_d;
  logic [CW-1:0] exec_cnt_q, exec_cnt_d;
  logic [CW-1:0] squash_cnt_q, squash_cnt_d;

  logic [RW-1:0] rd_mem_q   [0:1];
  logic [RW-1:0] rd_mem_d   [0:1];
  logic [DW-1:0] data_mem_q [0:1];
  logic [DW-1:0] data_mem_d [0:1];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;

  logic in_ready;
  logic accept;
  logic cond_pass;
  logic push;
  logic pop;

  cond_check u_cond_check (
    .cond (bus.in_cond),
    .nzcv (flags_q),
    .pass (cond_pass)
  );

  assign in_ready     = (count_q != 2'd2);
  assign accept       = bus.in_valid && in_ready;
  assign push         = accept && cond_pass && bus.in_reg_write;
  assign pop          = (count_q != 2'd0) && bus.wb_ready;

  assign bus.in_ready = in_ready;
  assign bus.wb_valid = (count_q != 2'd0);
  assign bus.wb_rd    = rd_mem_q[rd_ptr_q];
  assign bus.wb_data  = data_mem_q[rd_ptr_q];

  assign exec_cnt     = exec_cnt_q;
  assign squash_cnt   = squash_cnt_q;

  // Architectural state: flags and statistics only move on an accept.
  always_comb begin
    flags_d      = flags_q;
    exec_cnt_d   = exec_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (accept) begin
      if (cond_pass) begin
        if (bus.in_set_flags) begin
          flags_d = bus.in_flags;
        end
        if (exec_cnt_q != CNT_MAX) begin
          exec_cnt_d = exec_cnt_q + 1'b1;
        end
      end else if (squash_cnt_q != CNT_MAX) begin
        squash_cnt_d = squash_cnt_q + 1'b1;
      end
    end
  end

  // FIFO bookkeeping; push and pop in the same cycle leave occupancy unchanged.
  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      rd_mem_d[wr_ptr_q]   = bus.in_rd;
      data_mem_d[wr_ptr_q] = bus.in_result;
      wr_ptr_d             = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q       <= 4'b0000;
      exec_cnt_q    <= '0;
      squash_cnt_q  <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      rd_mem_q[0]   <= '0;
      rd_mem_q[1]   <= '0;
      data_mem_q[0] <= '0;
      data_mem_q[1] <= '0;
    end else begin
      flags_q       <= flags_d;
      exec_cnt_q    <= exec_cnt_d;
      squash_cnt_q  <= squash_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rd_mem_q[0]   <= rd_mem_d[0];
      rd_mem_q[1]   <= rd_mem_d[1];
      data_mem_q[0] <= data_mem_d[0];
      data_mem_q[1] <= data_mem_d[1];
    end
  end

endmodule

// File: tb/tb_cond_writeback.sv
// Randomised and directed stimulus for cond_writeback against a queue-based
// reference model; a negedge monitor compares every visible output.
module tb_cond_writeback;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [3:0]    flags_q;
  logic [CW-1:0] exec_cnt;
  logic [CW-1:0] squash_cnt;

  cond_writeback_if #(.DW(DW), .RW(RW)) bus ();

  cond_writeback #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flags_q    (flags_q),
    .exec_cnt   (exec_cnt),
    .squash_cnt (squash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] exp_q [$];
  logic [3:0]  m_flags;
  int          m_exec;
  int          m_squash;
  bit          pending_pop;

  function automatic bit cond_ok(input int c, input logic [3:0] f);
    bit n, z, cy, v;
    bit base [0:7];
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    base = '{z, cy, n, v, cy && !z, n == v, !z && (n == v), 1'b1};
    return base[c / 2] ^ bit'(c % 2);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: applies each edge's accept using its own occupancy view.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_flags     = 4'b0000;
        m_exec      = 0;
        m_squash    = 0;
        pending_pop = 0;
      end else begin
        int occ;
        occ = exp_q.size() + (pending_pop ? 1 : 0);
        pending_pop = 0;
        if (bus.in_valid && occ < 2) begin
          if (cond_ok(int'(bus.in_cond), m_flags)) begin
            if (m_exec < CNT_MAX) m_exec++;
            if (bus.in_reg_write)
              exp_q.push_back({28'd0, bus.in_rd, bus.in_result});
            if (bus.in_set_flags) m_flags = bus.in_flags;
          end else begin
            if (m_squash < CNT_MAX) m_squash++;
          end
        end
      end
    end
  end

  // Monitor: compares outputs mid-cycle and retires entries the next edge pops.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("wb_valid", {63'd0, bus.wb_valid}, {63'd0, exp_q.size() > 0});
      check("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_q.size() < 2});
      check("flags_q", {60'd0, flags_q}, {60'd0, m_flags});
      check("exec_cnt", {{(64-CW){1'b0}}, exec_cnt}, 64'(m_exec));
      check("squash_cnt", {{(64-CW){1'b0}}, squash_cnt}, 64'(m_squash));
      if (exp_q.size() > 0) begin
        check("wb_entry", {28'd0, bus.wb_rd, bus.wb_data}, exp_q[0]);
        if (rst_n && bus.wb_ready) begin
          $display("wb  rd=%0d data=%h", bus.wb_rd, bus.wb_data);
          void'(exp_q.pop_front());
          pending_pop = 1;
        end
      end
    end
  end

  task automatic drive(input logic [3:0] cond, input logic sf, input logic rw,
                       input logic [RW-1:0] rd, input logic [DW-1:0] res,
                       input logic [3:0] fl);
    bus.in_valid     = 1'b1;
    bus.in_cond      = cond;
    bus.in_set_flags = sf;
    bus.in_reg_write = rw;
    bus.in_rd        = rd;
    bus.in_result    = res;
    bus.in_flags     = fl;
  endtask

  task automatic wait_accept();
    bit r;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        $display("acc cond=%0d sf=%0b rw=%0b rd=%0d res=%h fl=%b",
                 bus.in_cond, bus.in_set_flags, bus.in_reg_write,
                 bus.in_rd, bus.in_result, bus.in_flags);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
  endtask

  task automatic send(input logic [3:0] cond, input logic sf, input logic rw,
                      input logic [RW-1:0] rd, input logic [DW-1:0] res,
                      input logic [3:0] fl);
    drive(cond, sf, rw, rd, res, fl);
    wait_accept();
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_cond      = 4'd0;
    bus.in_set_flags = 1'b0;
    bus.in_reg_write = 1'b0;
    bus.in_rd        = '0;
    bus.in_result    = '0;
    bus.in_flags     = 4'd0;
    bus.wb_ready     = 1'b1;
    do_reset(3);
    idle(2);

    // AL with flag set and write
    send(4'd14, 1'b1, 1'b1, 4'd3, 32'hFFFFFF10, 4'b1000);
    idle(2);

    // EQ fails under N-only flags, MI passes
    send(4'd0, 1'b0, 1'b1, 4'd5, 32'h0000_0099, 4'b0000);
    send(4'd4, 1'b0, 1'b1, 4'd5, 32'h0000_0012, 4'b0000);
    idle(2);

    // Back-pressure: third write held upstream until a slot frees
    bus.wb_ready = 1'b0;
    send(4'd14, 1'b0, 1'b1, 4'd1, 32'hA000_0001, 4'b0000);
    send(4'd14, 1'b0, 1'b1, 4'd2, 32'hA000_0002, 4'b0000);
    drive(4'd14, 1'b0, 1'b1, 4'd3, 32'hA000_0003, 4'b0000);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.wb_ready = 1'b1;
    wait_accept();
    idle(4);

    // Steady state at occupancy 1 with push and pop every cycle
    bus.wb_ready = 1'b0;
    send(4'd14, 1'b0, 1'b1, 4'd7, 32'hB000_0000, 4'b0000);
    bus.wb_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(4'd14, 1'b0, 1'b1, 4'(i), 32'hB000_0000 + i, 4'b0000);
      wait_accept();
    end
    idle(3);

    // Updated Z governs the very next instruction
    drive(4'd14, 1'b1, 1'b0, 4'd0, 32'd0, 4'b0100);
    wait_accept();
    drive(4'd1, 1'b0, 1'b1, 4'd9, 32'hDEAD_BEEF, 4'b0000);
    wait_accept();
    idle(2);

    // Randomised traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      bus.in_valid     = ($urandom_range(0, 9) < 7);
      bus.in_cond      = 4'($urandom_range(0, 15));
      bus.in_set_flags = 1'($urandom);
      bus.in_reg_write = 1'($urandom);
      bus.in_rd        = 4'($urandom);
      bus.in_result    = $urandom;
      bus.in_flags     = 4'($urandom);
      bus.wb_ready     = ($urandom_range(0, 9) < 6);
      rst_n            = ($urandom_range(0, 99) != 0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    bus.wb_ready = 1'b1;
    idle(4);

    // Reset with two entries buffered and an offered instruction
    bus.wb_ready = 1'b0;
    send(4'd14, 1'b1, 1'b1, 4'd4, 32'h1111_1111, 4'b1111);
    send(4'd14, 1'b0, 1'b1, 4'd6, 32'h2222_2222, 4'b0000);
    drive(4'd14, 1'b1, 1'b1, 4'd8, 32'h3333_3333, 4'b0101);
    do_reset(1);
    bus.in_valid = 1'b0;
    bus.wb_ready = 1'b1;
    idle(2);

    // Counter saturation
    for (int i = 0; i < CNT_MAX + 4; i++) send(4'd14, 1'b0, 1'b0, 4'd0, 32'd0, 4'b0000);
    for (int i = 0; i < CNT_MAX + 4; i++) send(4'd15, 1'b0, 1'b1, 4'd0, 32'd0, 4'b0000);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_writeback.md
COND_WRITEBACK -- requirements
Module: cond_writeback

Interface
REQ-001 SHALL have parameter DW, default 32, result/data width.
REQ-002 SHALL have parameter RW, default 4, destination register index width.
REQ-003 SHALL have parameter CW, default 16, width of the statistics counters.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-006 in_valid  input  1  upstream ALU result valid.
REQ-007 in_ready  output  1  block can accept an ALU result this cycle.
REQ-008 in_cond  input  4  condition field of the instruction.
REQ-009 in_set_flags  input  1  instruction updates NZCV.
REQ-010 in_reg_write  input  1  instruction writes a register.
REQ-011 in_rd  input  RW  destination register index.
REQ-012 in_result  input  DW  ALU out.
REQ-013 in_flags  input  4  ALU flags, bit order {N,Z,C,V}.
REQ-014 wb_valid  output  1  writeback entry available.
REQ-015 wb_ready  input  1  register file accepts entry.
REQ-016 wb_rd  output  RW  writeback register index.
REQ-017 wb_data  output  DW  writeback data.
REQ-018 flags_q  output  4  architectural NZCV register {N,Z,C,V}.
REQ-019 exec_cnt / squash_cnt  output  CW each  executed / condition-failed instruction counts.

Function
REQ-020 Accept = in_valid & in_ready at rising edge; in_ready SHALL be 1 iff buffer holds fewer than 2 entries (no same-cycle full bypass).
REQ-021 Condition SHALL be evaluated combinationally against current flags_q: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 never (fails).
REQ-022 On accept with condition pass and in_set_flags=1, flags_q SHALL load in_flags at that edge; new value governs the next accepted instruction.
REQ-023 On accept with condition pass and in_reg_write=1, {in_rd,in_result} SHALL be pushed into a 2-entry FIFO; wb_valid rises the cycle after accept (latency 1).
REQ-024 On accept with condition fail, no push, no flag change; squash_cnt increments.
REQ-025 On accept with condition pass, exec_cnt increments regardless of in_reg_write/in_set_flags.
REQ-026 Both counters SHALL saturate at all-ones, no wrap.
REQ-027 wb_valid = FIFO non-empty; wb_rd/wb_data = head entry, stable while wb_valid & !wb_ready.
REQ-028 Pop on wb_valid & wb_ready; simultaneous push and pop SHALL keep occupancy unchanged and preserve order.
REQ-029 FIFO pointers SHALL wrap modulo 2; occupancy held in a 2-bit count (0..2).
REQ-030 Flag update and push from one accept occur on the same edge; accepted-but-not-pushed instructions never stall.

Reset
REQ-031 While rst_n=0 at an edge: FIFO emptied, wb_valid=0, in_ready=1 next cycle, flags_q=4'b0000, exec_cnt=squash_cnt=0, wb_rd/wb_data=0.
REQ-032 Reset mid-operation SHALL discard buffered entries and any concurrent accept; no flag update occurs that cycle.

Structure
REQ-033 Condition-code encodings (EQ..NV) and flag bit positions (N=3,Z=2,C=1,V=0) SHALL live in the shared package with the ALU cmd encodings.
REQ-034 Condition evaluation SHALL be one combinational sub-module, cond_check (cond, nzcv -> pass).
REQ-035 FIFO SHALL be inline; no other sub-modules.

Verification
REQ-036 Reset, then accept in_cond=14, set_flags=1, reg_write=1, rd=3, result=0xFFFFFF10, flags=4'b1000 -> next cycle wb_valid=1, wb_rd=3, wb_data=0xFFFFFF10, flags_q=4'b1000, exec_cnt=1.
REQ-037 With flags_q=4'b1000, accept cond=0 (EQ) rd=5 -> no wb entry, squash_cnt=1; then cond=4 (MI) rd=5, result=0x12 -> wb_data=0x12.
REQ-038 Hold wb_ready=0, push 3 back-to-back AL writes -> in_ready=0 after second; third held upstream; release wb_ready -> entries drain in order, third accepted when count drops.
REQ-039 Occupancy 1, in_valid and wb_ready both high for 4 cycles -> count stays 1, output order matches input order.
REQ-040 Back-to-back: AL set_flags flags=4'b0100, then cond=1 (NE) -> second squashed using updated Z.
REQ-041 rst_n=0 with 2 entries buffered and in_valid=1 -> next cycle wb_valid=0, flags_q=0, counters 0.
